prv32_div_unit: RTL and testbench
=================================

// Module: prv32_div_unit
// PURPOSE
//   Iterative RV32M divider for DIV, DIVU, REM and REMU. It runs restoring division:
//   one subtract-and-compare per cycle, using the same subtract-with-carry arithmetic as the ALU.
//   Sits beside the ALU in EX. The core stalls while busy=1 and takes r when done=1.
//   Start/done handshake; one op in flight.
// PARAMETERS
//   W          32  operand/result width in bits (counter width = clog2(W))
//   FAST_SPCL  1   1: div-by-zero and signed overflow complete in 1 cycle; 0: they take the full iteration path
// PORTS
//   clk    in   1  clock, rising edge
//   rst_n  in   1  asynchronous reset, active low
//   start  in   1  request; sampled only in IDLE or DONE
//   op     in   2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   a      in   W  dividend (rs1)
//   b      in   W  divisor (rs2)
//   kill   in   1  synchronous flush; aborts any op in flight
//   busy   out  1  high in CALC and FIX
//   done   out  1  one-cycle pulse; r valid while high
//   r      out  W  quotient or remainder; held until the next op completes
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, busy=0, done=0, r=0, all internal registers=0.
// - Operand capture: on the start edge, op, |a|, |b|, sign(a) and sign(b) are latched.
//   a, b and op may change after that edge.
// - Signed ops: magnitude = two's complement negate if MSB=1.
//   0x80000000 keeps magnitude 2^31 as unsigned W bits.
// - FSM states: IDLE, CALC, FIX, DONE.
//   IDLE -start-> CALC (cnt=W-1), or -> DONE if FAST_SPCL and a special case applies.
//   CALC each edge:
//     rem_s = {rem[W-2:0], quo[W-1]}; quo <<= 1;
//     trial = {1'b0, rem_s} - {1'b0, |b|} (W+1 bits);
//     if trial[W]==0 then rem = trial[W-1:0] and quo[0] = 1, else rem = rem_s.
//     Leave CALC after the edge where cnt==0; otherwise cnt--.
//   FIX (one edge): apply sign correction, register r, go to DONE.
//   DONE: done=1 for exactly one cycle.
//     With start=1 -> CALC (back-to-back, no idle bubble).
//     Otherwise -> IDLE.
// - Latency: start sampled at edge T -> done high in the cycle after edge T+W+1.
//   Fast path: done high in the cycle after edge T.
// - Sign fix:
//   - DIV quotient is negated if sign(a)^sign(b).
//   - REM remainder is negated if sign(a).
//   - DIVU and REMU pass through unchanged.
// - Special cases (RISC-V semantics; same results with FAST_SPCL=0):
//   - b==0: DIV and DIVU give all-ones; REM and REMU give a.
//   - DIV with a=0x80000000 and b=0xFFFFFFFF gives 0x80000000.
//   - REM with the same operands gives 0.
// - start while busy=1 is ignored; the op in flight is not disturbed.
// - kill=1 on any edge: next state IDLE, busy=0, done=0, r unchanged.
//   kill has priority over start on the same edge.
// - Reset asserted mid-op: same as above, and r=0. No done is issued for the aborted op.
// - done and busy are never both 1.
// - r changes only on the edge that raises done.
// TESTING
// 1. DIVU a=100, b=7: done exactly W+1 cycles after start, r=14.
//    REMU with the same operands gives r=2. busy=1 in the cycles between.
// 2. DIV a=-7 (0xFFFFFFF9), b=2 -> r=0xFFFFFFFD.
//    REM with the same operands -> r=0xFFFFFFFF.
//    DIV a=7, b=-2 -> r=0xFFFFFFFD.
// 3. DIV a=5, b=0 -> r=0xFFFFFFFF, done in the cycle after start.
//    REMU a=5, b=0 -> r=5.
//    DIV a=0x80000000, b=0xFFFFFFFF -> r=0x80000000; REM with the same operands -> r=0.
// 4. Start DIVU 1000/10 and assert kill on cycle 10 -> busy=0 next cycle, no done pulse.
//    Then DIVU 9/3 -> r=3.
// 5. Pulse start again during the DONE cycle of DIVU 9/3 with REMU 10/4:
//    second done W+1 cycles later, r=2.
//    A start pulsed mid-CALC is ignored.
// 6. Deassert rst_n mid-CALC -> busy, done and r all 0 immediately, with no clock edge.
//    After release, DIVU 0xFFFFFFFF/1 -> r=0xFFFFFFFF.

Source files
------------

// File: rtl/prv32_div_unit.sv
// prv32_div_unit: iterative restoring divider for DIV/DIVU/REM/REMU.
// One subtract-and-compare per cycle; sign correction in a final FIX cycle.
// Divide-by-zero and signed overflow results are resolved at operand capture.
module prv32_div_unit #(
  parameter int W         = 32,
  parameter bit FAST_SPCL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         kill,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   rem_reg, quo_reg, dvs_reg, r_reg, spcl_val_reg;
  logic           op_rem_reg, sa_reg, sb_reg, spcl_reg;

  // Operand pre-processing for the capture edge (signs only count for signed ops)
  logic           sign_a, sign_b, b_zero, ovf, spcl_now, fast, accept;
  logic [W-1:0]   mag_a, mag_b, spcl_val_now;

  assign sign_a       = ~op[0] & a[W-1];
  assign sign_b       = ~op[0] & b[W-1];
  assign mag_a        = sign_a ? (~a + 1'b1) : a;
  assign mag_b        = sign_b ? (~b + 1'b1) : b;
  assign b_zero       = (b == '0);
  assign ovf          = ~op[0] & (a == MIN_NEG) & (b == '1);
  assign spcl_now     = b_zero | ovf;
  // b==0: quotient all-ones, remainder = dividend; overflow: quotient MIN, remainder 0
  assign spcl_val_now = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_NEG);
  assign fast         = FAST_SPCL & spcl_now;
  assign accept       = ((state_reg == S_IDLE) || (state_reg == S_DONE)) & start & ~kill;

  // One restoring step: shift next dividend bit into the partial remainder and trial-subtract
  logic [W-1:0]   rem_s;
  logic [W:0]     trial;
  logic [W-1:0]   quo_fix, rem_fix, result_fix;

  assign rem_s      = {rem_reg[W-2:0], quo_reg[W-1]};
  assign trial      = {1'b0, rem_s} - {1'b0, dvs_reg};
  assign quo_fix    = (sa_reg ^ sb_reg) ? (~quo_reg + 1'b1) : quo_reg;
  assign rem_fix    = sa_reg ? (~rem_reg + 1'b1) : rem_reg;
  assign result_fix = spcl_reg ? spcl_val_reg : (op_rem_reg ? rem_fix : quo_fix);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; kill overrides everything including a same-edge start
  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start) state_next = fast ? S_DONE : S_CALC;
        S_CALC:  if (cnt_reg == '0) state_next = S_FIX;
        S_FIX:   state_next = S_DONE;
        S_DONE:  state_next = start ? (fast ? S_DONE : S_CALC) : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state so busy and done are mutually exclusive
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      S_CALC:  busy = 1'b1;
      S_FIX:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign r = r_reg;

  // Datapath: operand capture, iteration, and result register (written only when entering DONE)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      r_reg        <= '0;
      spcl_val_reg <= '0;
      op_rem_reg   <= 1'b0;
      sa_reg       <= 1'b0;
      sb_reg       <= 1'b0;
      spcl_reg     <= 1'b0;
    end else if (accept) begin
      cnt_reg      <= CW'(W - 1);
      rem_reg      <= '0;
      quo_reg      <= mag_a;
      dvs_reg      <= mag_b;
      spcl_val_reg <= spcl_val_now;
      op_rem_reg   <= op[1];
      sa_reg       <= sign_a;
      sb_reg       <= sign_b;
      spcl_reg     <= spcl_now;
      if (fast) r_reg <= spcl_val_now;
    end else if (!kill) begin
      if (state_reg == S_CALC) begin
        cnt_reg <= cnt_reg - 1'b1;
        quo_reg <= {quo_reg[W-2:0], ~trial[W]};
        rem_reg <= trial[W] ? rem_s : trial[W-1:0];
      end else if (state_reg == S_FIX) begin
        r_reg <= result_fix;
      end
    end
  end

endmodule

// File: tb/tb_prv32_div_unit.sv
// tb_prv32_div_unit: directed checks of the iterative divider.
module tb_prv32_div_unit;

  localparam int W = 32;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          kill = 1'b0;
  logic          busy, done;
  logic [W-1:0]  r;

  int checks = 0;
  int errors = 0;

  prv32_div_unit #(.W(W), .FAST_SPCL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .r(r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; n = cycles after the capture edge, busy_ok = busy held meanwhile
  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
  endtask

  // Issues one op, scrambles the inputs after capture, waits for done
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int n, output bit busy_ok);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    wait_done(n, busy_ok);
  endtask

  initial begin
    int n;
    bit bok;
    bit saw_done;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_r", r, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. Unsigned divide / remainder
    run_op(DIVU, 32'd100, 32'd7, n, bok);
    check("divu_latency", 32'(n), 32'(W + 1));
    check("divu_busy_between", 32'(bok), 32'd1);
    check("divu_busy_at_done", 32'(busy), 32'd0);
    check("divu_100_7", r, 32'd14);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    $display("DIVU 100/7 -> %h after %0d cycles", r, n);
    run_op(REMU, 32'd100, 32'd7, n, bok);
    check("remu_latency", 32'(n), 32'(W + 1));
    check("remu_100_7", r, 32'd2);
    $display("REMU 100/7 -> %h", r);
    tick();

    // 2. Signed
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, n, bok);
    check("div_m7_2", r, 32'hFFFF_FFFD);
    $display("DIV -7/2 -> %h", r);
    tick();
    run_op(REM, 32'hFFFF_FFF9, 32'd2, n, bok);
    check("rem_m7_2", r, 32'hFFFF_FFFF);
    $display("REM -7/2 -> %h", r);
    tick();
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, n, bok);
    check("div_7_m2", r, 32'hFFFF_FFFD);
    $display("DIV 7/-2 -> %h", r);
    tick();

    // 3. Special cases (fast path)
    run_op(DIV, 32'd5, 32'd0, n, bok);
    check("div0_latency", 32'(n), 32'd0);
    check("div_5_0", r, 32'hFFFF_FFFF);
    $display("DIV 5/0 -> %h after %0d cycles", r, n);
    tick();
    run_op(REMU, 32'd5, 32'd0, n, bok);
    check("remu_5_0", r, 32'd5);
    $display("REMU 5/0 -> %h", r);
    tick();

    // 4. Kill mid-op: no done, r holds its previous value
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd10;
    tick();
    start = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("kill_no_done", 32'(saw_done), 32'd0);
    check("kill_r_hold", r, 32'd5);
    $display("kill DIVU 1000/10 -> r held %h", r);

    // 5. Back-to-back start in DONE, plus a mid-CALC start that must be ignored
    run_op(DIVU, 32'd9, 32'd3, n, bok);
    check("divu_9_3", r, 32'd3);
    $display("DIVU 9/3 -> %h", r);
    start = 1'b1; op = REMU; a = 32'd10; b = 32'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd1;
    tick();
    start = 1'b0;
    wait_done(n, bok);
    check("b2b_latency", 32'(n + 3), 32'(W + 1));
    check("b2b_remu_10_4", r, 32'd2);
    $display("REMU 10/4 back-to-back -> %h after %0d cycles", r, n + 3);
    tick();

    // Signed overflow
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, bok);
    check("ovf_latency", 32'(n), 32'd0);
    check("div_ovf", r, 32'h8000_0000);
    $display("DIV MIN/-1 -> %h", r);
    tick();
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, n, bok);
    check("rem_ovf", r, 32'd0);
    $display("REM MIN/-1 -> %h", r);
    tick();

    // 6. Async reset mid-CALC, then a full-width divide
    run_op(DIVU, 32'd9, 32'd3, n, bok);
    tick();
    start = 1'b1; op = DIVU; a = 32'd50; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_r", r, 32'd0);
    $display("async reset mid-CALC -> busy=%b done=%b r=%h", busy, done, r);
    #1 rst_n = 1'b1;
    tick();
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, n, bok);
    check("post_rst_latency", 32'(n), 32'(W + 1));
    check("divu_max_1", r, 32'hFFFF_FFFF);
    $display("DIVU FFFFFFFF/1 -> %h", r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
